ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter: LAT, 2, BUSY cycles before ACCESS (0..15).
REQ-002 SHALL have parameter: DEPTH, 1024, storage size in 32-bit words (power of 2).
REQ-003 SHALL have port: CLK  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: ramaddr  input  32  byte address; bits [1:0] ignored.
REQ-006 SHALL have port: ramstore  input  32  write data.
REQ-007 SHALL have port: ramREN  input  1  read request, level, held until ACCESS is seen.
REQ-008 SHALL have port: ramWEN  input  1  write request, level, held until ACCESS is seen.
REQ-009 SHALL have port: ramload  output  32  read data, valid while ramstate==ACCESS after a read.
REQ-010 SHALL have port: ramstate  output  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, ACC, ERR; ramstate decoded from the state register only: IDLE->FREE, WAIT->BUSY, ACC->ACCESS, ERR->ERROR.
REQ-012 SHALL treat a request as valid when exactly one of ramREN/ramWEN is high and word index ramaddr[31:2] < DEPTH.
REQ-013 SHALL treat a request as invalid when both ramREN and ramWEN are high, or the word index >= DEPTH.
REQ-014 In IDLE, on a valid request at cycle T, SHALL capture the address and operation, load the counter with LAT, and go to WAIT (LAT>0) or ACC (LAT==0).
REQ-015 With LAT>0, ramstate SHALL be BUSY for cycles T+1..T+LAT and ACCESS at T+LAT+1; with LAT==0, ACCESS at T+1.
REQ-016 In WAIT, SHALL decrement the counter each cycle and enter ACC on the edge where the counter reaches 0.
REQ-017 In WAIT, if the request drops or the address or operation differs from the captured values, SHALL return to IDLE (abort); an aborted write SHALL NOT modify storage.
REQ-018 On entry to ACC for a read, SHALL register ramload <= mem[captured word index].
REQ-019 For a write, SHALL store ramstore, sampled on the edge that ends the ACC cycle, to mem[captured word index].
REQ-020 ACC SHALL last exactly one cycle and then go to IDLE unconditionally, so back-to-back requests see one FREE cycle between accesses.
REQ-021 In IDLE, an invalid request SHALL go to ERR; ERR SHALL persist while any request is asserted and return to IDLE when both ramREN and ramWEN are low.
REQ-022 ramload SHALL hold its last read value in all other cycles; writes SHALL NOT alter ramload.
REQ-023 The counter SHALL be 4 bits wide and SHALL NOT wrap; it saturates at 0.
REQ-024 A read of an address in the cycle after a write to it completes SHALL return the new data.

Reset
REQ-025 While nRST==0, SHALL force state=IDLE (ramstate=FREE), ramload=0, counter=0, and captured address/operation=0, regardless of CLK.
REQ-026 Storage contents SHALL NOT be reset; a write in progress when reset is asserted SHALL be aborted with storage unchanged.

Structure
REQ-027 SHALL import word_t and ramstate_t from cpu_types_pkg; the FSM state enum SHALL be local to the module.
REQ-028 SHALL place storage in one sub-module, ram_array: DEPTH x 32, synchronous write, combinational read.

Verification
REQ-029 Reset, then idle -> ramstate=FREE, ramload=0x00000000.
REQ-030 LAT=2: write 0xDEADBEEF to 0x40, then read 0x40 -> write shows BUSY,BUSY,ACCESS; read shows FREE,BUSY,BUSY,ACCESS with ramload=0xDEADBEEF during ACCESS.
REQ-031 LAT=2: write 0x11111111 to 0x80, change ramaddr to 0x84 during BUSY, drop the request, then read 0x80 -> write aborted (FREE follows), read returns the prior value 0x0 (0x80 preloaded with 0).
REQ-032 ramREN=ramWEN=1 at 0x0, and separately a read of 0x00001000 with DEPTH=1024 -> ERROR from the next cycle until the request drops, then FREE; storage unchanged.
REQ-033 LAT=0: read 0x40 -> ACCESS on T+1 with ramload=0xDEADBEEF (0x40 preloaded with 0xDEADBEEF).
REQ-034 LAT=3: assert nRST=0 mid-BUSY of a write of 0xCAFEF00D to 0x10 (0x10 preloaded with 0x0) -> immediate FREE; a subsequent read of 0x10 returns 0x0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data word and the RAM handshake state seen by the requester.
// No logic; types only, so there is no latency or backpressure.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_responder_if.sv
// Requester <-> RAM bundle: level-held request in, handshake state and read data out.
// Requester holds REN/WEN until ACCESS is observed, which is the only backpressure.
interface ram_responder_if;
    import cpu_types_pkg::*;

    word_t     ramaddr;
    word_t     ramstore;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramaddr, ramstore, ramREN, ramWEN,
        input  ramload, ramstate
    );

    modport slave (
        input  ramaddr, ramstore, ramREN, ramWEN,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_array.sv
// DEPTH x 32 storage: write lands on the rising edge, read is combinational.
// No reset and no backpressure; contents survive reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);
    word_t mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/ram_responder.sv
// Word RAM with LAT BUSY cycles then one ACCESS cycle; ERROR on malformed requests.
// Requester must hold the request unchanged through BUSY; any change aborts back to FREE.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024
) (
    input logic            CLK,
    input logic            nRST,
    ram_responder_if.slave rif
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          op_wr_q, op_wr_d;
    word_t         ramload_q;
    word_t         rdata;

    logic [29:0] widx;
    logic        one_req, any_req, in_range, req_valid, req_same;
    logic        mem_we, load_en;
    logic        unused_ok;

    assign widx      = rif.ramaddr[31:2];
    assign one_req   = rif.ramREN ^ rif.ramWEN;
    assign any_req   = rif.ramREN | rif.ramWEN;
    assign in_range  = widx < 30'(DEPTH);
    assign req_valid = one_req && in_range;
    // In range implies upper index bits are zero, so low-bit equality is full equality.
    assign req_same  = req_valid && (widx[AW-1:0] == addr_q) && (rif.ramWEN == op_wr_q);
    assign unused_ok = ^rif.ramaddr[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        op_wr_d = op_wr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = widx[AW-1:0];
                    op_wr_d = rif.ramWEN;
                    cnt_d   = 4'(LAT);
                    state_d = (LAT == 0) ? ACC : WAIT;
                end else if (any_req) begin
                    state_d = ERR;
                end
            end
            WAIT: begin
                if (!req_same) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = ACC;
                end
            end
            ACC:     state_d = IDLE;
            ERR:     if (!any_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes commit only on the edge closing ACC, so aborts and resets never touch storage.
    assign mem_we  = (state_q == ACC) && op_wr_q;
    assign load_en = (state_d == ACC) && !op_wr_d;

    ram_array #(.DEPTH(DEPTH)) u_mem (
        .CLK     (CLK),
        .we_i    (mem_we),
        .waddr_i (addr_q),
        .wdata_i (rif.ramstore),
        .raddr_i (addr_d),
        .rdata_o (rdata)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            op_wr_q   <= 1'b0;
            ramload_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            op_wr_q <= op_wr_d;
            if (load_en) ramload_q <= rdata;
        end
    end

    always_comb begin
        rif.ramstate = FREE;
        case (state_q)
            IDLE:    rif.ramstate = FREE;
            WAIT:    rif.ramstate = BUSY;
            ACC:     rif.ramstate = ACCESS;
            ERR:     rif.ramstate = ERROR;
            default: rif.ramstate = FREE;
        endcase
    end

    assign rif.ramload = ramload_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=0, 2 and 3; stimulus queues expected per-cycle
// state/load, a negedge monitor pops and compares against the selected instance.
module tb_ram_responder;
    import cpu_types_pkg::*;

    typedef struct {
        ramstate_t st;
        bit        chk;
        word_t     ld;
        int        id;
    } exp_t;

    logic  clk = 1'b0;
    logic  nrst = 1'b0;
    logic  ren = 1'b0, wen = 1'b0;
    word_t addr = '0, wdata = '0;
    int    sel = 0;

    exp_t  expq[$];
    exp_t  e;
    int    n_vec = 0, n_bad = 0, vec_id = 0;
    ramstate_t st_act;
    word_t     ld_act;

    always #5 clk = ~clk;

    ram_responder_if if0 ();
    ram_responder_if if2 ();
    ram_responder_if if3 ();

    assign if0.ramREN = ren && (sel == 0);
    assign if0.ramWEN = wen && (sel == 0);
    assign if2.ramREN = ren && (sel == 2);
    assign if2.ramWEN = wen && (sel == 2);
    assign if3.ramREN = ren && (sel == 3);
    assign if3.ramWEN = wen && (sel == 3);
    assign if0.ramaddr = addr;  assign if0.ramstore = wdata;
    assign if2.ramaddr = addr;  assign if2.ramstore = wdata;
    assign if3.ramaddr = addr;  assign if3.ramstore = wdata;

    ram_responder #(.LAT(0), .DEPTH(1024)) u_lat0 (.CLK(clk), .nRST(nrst), .rif(if0));
    ram_responder #(.LAT(2), .DEPTH(1024)) u_lat2 (.CLK(clk), .nRST(nrst), .rif(if2));
    ram_responder #(.LAT(3), .DEPTH(1024)) u_lat3 (.CLK(clk), .nRST(nrst), .rif(if3));

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            e = expq.pop_front();
            case (sel)
                0:       begin st_act = if0.ramstate; ld_act = if0.ramload; end
                2:       begin st_act = if2.ramstate; ld_act = if2.ramload; end
                default: begin st_act = if3.ramstate; ld_act = if3.ramload; end
            endcase
            n_vec++;
            if (st_act !== e.st) begin
                n_bad++;
                $display("FAIL ramstate lat%0d v%0d: got %0d want %0d", sel, e.id, st_act, e.st);
            end
            if (e.chk) begin
                n_vec++;
                if (ld_act !== e.ld) begin
                    n_bad++;
                    $display("FAIL ramload lat%0d v%0d: got %08h want %08h", sel, e.id, ld_act, e.ld);
                end
            end
        end
    end

    // Drive one cycle of inputs and queue what the DUT must show during that cycle.
    task automatic cyc(input bit r, input bit w, input word_t a, input word_t d,
                       input ramstate_t st, input bit chk, input word_t ld);
        ren = r; wen = w; addr = a; wdata = d;
        expq.push_back('{st: st, chk: chk, ld: ld, id: vec_id});
        vec_id++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit chk, input word_t ld);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, FREE, chk, ld);
    endtask

    task automatic xfer(input bit w, input word_t a, input word_t d, input int lat, input word_t ld);
        cyc(!w, w, a, d, FREE, 1'b0, 32'h0);
        for (int i = 0; i < lat; i++) cyc(!w, w, a, d, BUSY, 1'b0, 32'h0);
        cyc(!w, w, a, d, ACCESS, !w, ld);
    endtask

    initial begin
        @(posedge clk); #1;
        // Held in reset: every instance idles with cleared read data.
        sel = 0; idle(1'b1, 32'h0);
        sel = 2; idle(1'b1, 32'h0);
        sel = 3; idle(1'b1, 32'h0);
        nrst = 1'b1;
        idle(1'b1, 32'h0);
        sel = 0; idle(1'b1, 32'h0);

        // LAT=2: write then read back.
        sel = 2;
        xfer(1'b1, 32'h40, 32'hDEADBEEF, 2, 32'h0);
        idle(1'b1, 32'h0);
        xfer(1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF);
        idle(1'b1, 32'hDEADBEEF);

        // LAT=2: aborted write keeps the old word and does not disturb ramload.
        xfer(1'b1, 32'h80, 32'h0, 2, 32'h0);
        idle(1'b1, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 32'h80, 32'h11111111, FREE, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h84, 32'h11111111, BUSY, 1'b1, 32'hDEADBEEF);
        cyc(1'b0, 1'b0, 32'h84, 32'h0, FREE, 1'b1, 32'hDEADBEEF);
        idle(1'b0, 32'h0);
        xfer(1'b0, 32'h80, 32'h0, 2, 32'h0);
        idle(1'b1, 32'h0);

        // LAT=2: both strobes, then out-of-range index; storage at word 0 untouched.
        xfer(1'b1, 32'h0, 32'h0000A5A5, 2, 32'h0);
        idle(1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0, 32'hBAD0BAD0, FREE, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0, 32'hBAD0BAD0, ERROR, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0, 32'hBAD0BAD0, ERROR, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, ERROR, 1'b0, 32'h0);
        idle(1'b1, 32'h0);
        cyc(1'b1, 1'b0, 32'h1000, 32'h0, FREE, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h1000, 32'h0, ERROR, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, ERROR, 1'b1, 32'h0);
        idle(1'b0, 32'h0);
        xfer(1'b0, 32'h0, 32'h0, 2, 32'h0000A5A5);
        idle(1'b0, 32'h0);

        // LAT=0: single-cycle access, and read-after-write with one FREE gap.
        sel = 0;
        xfer(1'b1, 32'h40, 32'hDEADBEEF, 0, 32'h0);
        idle(1'b0, 32'h0);
        xfer(1'b0, 32'h40, 32'h0, 0, 32'hDEADBEEF);
        idle(1'b1, 32'hDEADBEEF);
        xfer(1'b1, 32'h44, 32'h12345678, 0, 32'h0);
        xfer(1'b0, 32'h44, 32'h0, 0, 32'h12345678);
        idle(1'b1, 32'h12345678);

        // LAT=3: reset mid-BUSY of a write aborts it.
        sel = 3;
        xfer(1'b1, 32'h10, 32'h0, 3, 32'h0);
        idle(1'b0, 32'h0);
        xfer(1'b1, 32'h14, 32'h5A5A5A5A, 3, 32'h0);
        idle(1'b0, 32'h0);
        xfer(1'b0, 32'h14, 32'h0, 3, 32'h5A5A5A5A);
        idle(1'b1, 32'h5A5A5A5A);
        cyc(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, FREE, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, BUSY, 1'b0, 32'h0);
        nrst = 1'b0;
        cyc(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, FREE, 1'b1, 32'h0);
        nrst = 1'b1;
        idle(1'b1, 32'h0);
        xfer(1'b0, 32'h10, 32'h0, 3, 32'h0);
        idle(1'b1, 32'h0);

        @(posedge clk); #1;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
